i2c_recv: RTL and testbench

Master-side I2C byte receiver, the read-direction counterpart of the byte transmitter i2c_send. On request, it generates 9 SCL pulses and releases SDA for 8 of them, sampling the slave's data MSB first. On the 9th pulse it drives ACK or NACK. It sits beside i2c_send under the I2C master controller, which owns START/STOP generation and byte sequencing.

---
 rtl/i2c_recv.sv | 183 ++++++++++++++++++
 tb/tb_i2c_recv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_recv.sv
`timescale 1ns/1ps
// i2c_recv -- master-side I2C byte receiver.
//
// On an accepted request, generates 9 SCL pulses. For the first 8 it keeps SDA
// released and samples the slave's data MSB first at mid-high (last clock of
// quarter Q2). On the 9th pulse it drives ACK (SDA low) or NACK (released).
// START/STOP generation and byte sequencing belong to the enclosing master.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rd_req     level request for one byte; sampled only in IDLE or on byte_done
//   ack_en     1 = ACK after the byte, 0 = NACK; captured on acceptance
//   i2c_scl    SCL output
//   i2c_sda    open-drain SDA (driven 0 or high-Z, never driven high)
//   sda_oe     high while this block pulls SDA low
//   rd_data    received byte, valid from byte_done to the next byte_done
//   byte_done  one-cycle pulse in the last clock of the ACK bit
//   busy       high from the cycle after acceptance through byte_done
//
// All outputs are registered. The *_d values describe the cycle that follows
// the next edge, so outputs are computed from the next-state values.
module i2c_recv #(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       ack_en,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       sda_oe,
  output logic [7:0] rd_data,
  output logic       byte_done,
  output logic       busy
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QTR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;     // clock within quarter
  logic [1:0]      qph_q, qph_d;       // quarter within bit (Q0..Q3)
  logic [3:0]      bit_q, bit_d;       // bits completed in this byte (0..8)
  logic [7:0]      shreg_q, shreg_d;
  logic            ack_q, ack_d;       // captured ack_en
  logic            owned_q, owned_d;   // a byte has completed; keep SCL low in IDLE
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            q_end;
  logic            b_end;
  logic            sda_in;
  logic            in_byte;

  // Anything other than a solid 0 (1, X, Z) reads as 1: the bus is pulled up.
  assign sda_in = (i2c_sda !== 1'b0);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qph_d     = qph_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    ack_d     = ack_q;
    owned_d   = owned_q;

    accept = rd_req && ((state_q == IDLE) || done_q);
    q_end  = (qcnt_q == Q_LAST);
    b_end  = q_end && (qph_q == 2'd3);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BIT;
          qcnt_d  = '0;
          qph_d   = 2'd0;
          bit_d   = 4'd0;
          ack_d   = ack_en;
        end
      end

      BIT: begin
        // Mid-high sample point: last clock of Q2.
        if ((qph_q == 2'd2) && q_end)
          shreg_d = {shreg_q[6:0], sda_in};
        if (q_end) begin
          qcnt_d = '0;
          qph_d  = qph_q + 2'd1;
          if (b_end) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7)
              state_d = ACK;
          end
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end

      ACK: begin
        if (b_end) begin
          // done_q is high in exactly this cycle, so a back-to-back
          // request is accepted here and the next Q0 follows directly.
          qcnt_d  = '0;
          qph_d   = 2'd0;
          bit_d   = 4'd0;
          owned_d = 1'b1;
          if (accept) begin
            state_d = BIT;
            ack_d   = ack_en;
          end else begin
            state_d = IDLE;
          end
        end else if (q_end) begin
          qcnt_d = '0;
          qph_d  = qph_q + 2'd1;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_byte   = (state_d != IDLE);
    // SCL is high in Q2/Q3; between bytes it is low once the bus is owned.
    scl_d     = in_byte ? qph_d[1] : ~owned_d;
    sda_oe_d  = (state_d == ACK) && ack_d;
    done_d    = (state_d == ACK) && (qph_d == 2'd3) && (qcnt_d == Q_LAST);
    rd_data_d = done_d ? shreg_d : rd_data_q;
    busy_d    = in_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      qph_q     <= 2'd0;
      bit_q     <= 4'd0;
      shreg_q   <= 8'h00;
      ack_q     <= 1'b0;
      owned_q   <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      rd_data_q <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qph_q     <= qph_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      ack_q     <= ack_d;
      owned_q   <= owned_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign i2c_scl   = scl_q;
  assign sda_oe    = sda_oe_q;
  assign rd_data   = rd_data_q;
  assign byte_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_recv.sv
`timescale 1ns/1ps
// Directed bench for i2c_recv with QTR=4 (16 clocks per SCL pulse, 144 per byte).
// A simple slave model drives its byte MSB first, changing SDA only after SCL
// falls; SDA has a pull-up so a released bus reads 1.
module tb_i2c_recv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic       ack_en = 1'b0;
  logic       i2c_scl;
  logic       sda_oe;
  logic [7:0] rd_data;
  logic       byte_done;
  logic       busy;
  wire        sda;

  int n_chk = 0;
  int n_err = 0;

  // slave model state
  logic [7:0] load_data = 8'h00;
  logic [7:0] nxt_data  = 8'h00;
  logic [7:0] slv_data  = 8'h00;
  logic       slv_clr   = 1'b0;
  logic       glitch_en = 1'b0;
  logic       glitch    = 1'b0;
  logic       scl_prev  = 1'b1;
  logic       slv_low;
  int         rise_cnt  = 0;
  int         slv_idx   = 0;

  i2c_recv #(.QTR(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .ack_en    (ack_en),
    .i2c_scl   (i2c_scl),
    .i2c_sda   (sda),
    .sda_oe    (sda_oe),
    .rd_data   (rd_data),
    .byte_done (byte_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  pullup (sda);
  assign slv_low = (slv_idx < 8) && !(slv_data[3'(7 - slv_idx)] ^ glitch);
  assign sda = slv_low ? 1'b0 : 1'bz;

  // Bit index advances on each SCL fall after a rise; after the 9th pulse the
  // next byte (nxt_data) is loaded for back-to-back transfers.
  always @(i2c_scl or slv_clr) begin
    if (slv_clr) begin
      rise_cnt = 0;
      slv_idx  = 0;
      slv_data = load_data;
    end else if (i2c_scl && !scl_prev) begin
      rise_cnt++;
    end else if (!i2c_scl && scl_prev) begin
      if (rise_cnt == 9) begin
        rise_cnt = 0;
        slv_data = nxt_data;
      end
      slv_idx = rise_cnt;
    end
    scl_prev = i2c_scl;
  end

  // Invert SDA for most of Q3, just after the Q2 sample edge.
  always @(posedge i2c_scl) begin
    if (glitch_en) begin
      repeat (4) @(posedge clk);
      #1 glitch = 1'b1;
      repeat (3) @(posedge clk);
      #1 glitch = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slv_load(input logic [7:0] d);
    load_data = d;
    slv_clr = 1'b1;
    #1 slv_clr = 1'b0;
  endtask

  // One isolated byte. ack_en is flipped right after acceptance to show it was
  // captured; with poke, rd_req is pulsed mid-byte and must be ignored.
  task automatic rx_byte(input string tag, input logic ack, input logic [7:0] d, input bit poke);
    int   done_k = 0;
    int   oe_cnt = 0;
    int   oe_data = 0;
    int   rises = 0;
    int   busy_bad = 0;
    int   extra = 0;
    logic prev = 1'b0;
    logic sda9 = 1'bx;
    @(negedge clk);
    slv_load(d);
    ack_en = ack;
    rd_req = 1'b1;
    @(posedge clk);
    #1 rd_req = 1'b0;
    ack_en = ~ack;
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      @(negedge clk);
      if (poke && k == 50) rd_req = 1'b1;
      if (poke && k == 51) rd_req = 1'b0;
      if (sda_oe) begin
        oe_cnt++;
        if (k <= 128) oe_data++;
      end
      if (i2c_scl && !prev) rises++;
      prev = i2c_scl;
      if (!busy) busy_bad++;
      if (k == 137) sda9 = sda;
      if (byte_done) done_k = k;
    end
    chk({tag, "_done_cycle"}, done_k, 144);
    chk({tag, "_rd_data"}, {24'h0, rd_data}, {24'h0, d});
    chk({tag, "_scl_pulses"}, rises, 9);
    chk({tag, "_oe_ack_clocks"}, oe_cnt, ack ? 16 : 0);
    chk({tag, "_oe_in_data"}, oe_data, 0);
    chk({tag, "_sda_9th"}, {31'h0, sda9}, {31'h0, ~ack});
    chk({tag, "_busy_low"}, busy_bad, 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'h0, busy}, 0);
    chk({tag, "_scl_idle_low"}, {31'h0, i2c_scl}, 0);
    if (poke) begin
      for (int k = 0; k < 160; k++) begin
        @(negedge clk);
        if (byte_done) extra++;
      end
      chk({tag, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b [3];
    int nd;
    int last;
    int busy_bad;
    bit after_done;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'h0, i2c_scl}, 1);
    chk("rst_oe", {31'h0, sda_oe}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, byte_done}, 0);
    chk("rst_rd_data", {24'h0, rd_data}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    rx_byte("a5_ack", 1'b1, 8'hA5, 1'b0);
    rx_byte("3c_nack", 1'b0, 8'h3C, 1'b0);

    // back-to-back with rd_req held high
    exp_b = '{8'hF0, 8'hF1, 8'hF2};
    nd = 0;
    last = 0;
    busy_bad = 0;
    after_done = 1'b0;
    @(negedge clk);
    nxt_data = 8'hF1;
    slv_load(8'hF0);
    ack_en = 1'b1;
    rd_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 600 && nd < 3; k++) begin
      @(negedge clk);
      if (after_done) begin
        chk("b2b_scl_gap", {31'h0, i2c_scl}, 0);
        after_done = 1'b0;
        if (nd == 1) nxt_data = 8'hF2;
        if (nd == 2) rd_req = 1'b0;
      end
      if (!busy) busy_bad++;
      if (byte_done) begin
        chk("b2b_interval", k - last, 144);
        chk("b2b_rd_data", {24'h0, rd_data}, {24'h0, exp_b[nd]});
        nd++;
        last = k;
        after_done = 1'b1;
      end
    end
    rd_req = 1'b0;
    chk("b2b_count", nd, 3);
    chk("b2b_busy_low", busy_bad, 0);
    @(negedge clk);
    chk("b2b_busy_after", {31'h0, busy}, 0);
    chk("b2b_scl_after", {31'h0, i2c_scl}, 0);

    // Q3 glitches must not be captured
    glitch_en = 1'b1;
    rx_byte("glitch", 1'b1, 8'hC3, 1'b0);
    glitch_en = 1'b0;

    // rd_req while busy is ignored
    rx_byte("poke", 1'b1, 8'h96, 1'b1);

    // reset in bit 4, then a clean byte
    @(negedge clk);
    slv_load(8'h5A);
    ack_en = 1'b1;
    rd_req = 1'b1;
    @(posedge clk);
    #1 rd_req = 1'b0;
    repeat (70) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_scl", {31'h0, i2c_scl}, 1);
    chk("mid_rst_oe", {31'h0, sda_oe}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_rd_data", {24'h0, rd_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rx_byte("post_rst", 1'b1, 8'h69, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
